// File: rtl/uart_ctr_pkg.sv
// Shared constants for the uart0 snoop-bus sink: bus field offsets,
// 16550 register indices and the console end-of-line byte.
package uart_ctr_pkg;

  localparam int PWDATA_LSB  = 96;
  localparam int PADDR_LSB   = 64;
  localparam int PWRITE_BIT  = 32;
  localparam int PENABLE_BIT = 0;

  localparam logic [3:0] REG_THR      = 4'h0;
  localparam logic [3:0] REG_LCR      = 4'h3;
  localparam int         LCR_DLAB_BIT = 7;

  localparam logic [7:0] EOL_BYTE = 8'h0A;

  function automatic logic is_eol(input logic [7:0] b);
    return (b == EOL_BYTE);
  endfunction

endpackage

// File: rtl/uart_ctr_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible on pop_data while not
// empty. A push into a full FIFO is accepted only when a pop frees a slot.
module uart_ctr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == LW'(DEPTH));
  assign empty     = (count_r == {LW{1'b0}});
  assign level     = count_r;
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {LW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + LW'(1);
        2'b01:   count_r <= count_r - LW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, cleared on reset so stale bytes never reappear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Head entry, forced to zero while empty.
  always_comb begin
    pop_data = {WIDTH{1'b0}};
    if (!empty) begin
      pop_data = mem_r[rd_ptr_r];
    end else begin
      pop_data = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/uart_ctr_sink.sv
// Snoops uart0 APB writes, tracks LCR.DLAB and queues THR bytes for the
// simulation harness as a valid/ready byte stream with drop accounting.
module uart_ctr_sink
  import uart_ctr_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [3:0] ADDR_THR   = 4'h0,
  parameter logic [3:0] ADDR_LCR   = 4'h3
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [127:0]                  uart_ctr_bus,
  output logic                          char_valid,
  input  logic                          char_ready,
  output logic [7:0]                    char_data,
  output logic                          char_eol,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          dlab,
  output logic [15:0]                   ovf_cnt
);

  logic        acc_s;
  logic        acc_q_r;
  logic        wr_evt_s;
  logic [3:0]  paddr_s;
  logic [7:0]  pwbyte_s;
  logic        dlab_r;
  logic        lcr_wr_s;
  logic        thr_push_s;
  logic        pop_s;
  logic        full_s;
  logic        empty_s;
  logic        drop_s;
  logic [15:0] ovf_cnt_r;
  logic [7:0]  head_s;
  logic        bus_unused_s;

  assign acc_s    = uart_ctr_bus[PENABLE_BIT] & uart_ctr_bus[PWRITE_BIT];
  assign wr_evt_s = acc_s & ~acc_q_r;
  assign paddr_s  = uart_ctr_bus[PADDR_LSB +: 4];
  assign pwbyte_s = uart_ctr_bus[PWDATA_LSB +: 8];

  assign bus_unused_s = ^{uart_ctr_bus[127:PWDATA_LSB+8],
                          uart_ctr_bus[PWDATA_LSB-1:PADDR_LSB+4],
                          uart_ctr_bus[PADDR_LSB-1:PWRITE_BIT+1],
                          uart_ctr_bus[PWRITE_BIT-1:PENABLE_BIT+1]};

  // Access-phase history so a wait-stated write yields a single event.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      acc_q_r <= 1'b0;
    end else begin
      acc_q_r <= acc_s;
    end
  end

  // Register decode; a THR write while DLAB is set is a DLL write and is dropped.
  always_comb begin
    lcr_wr_s   = 1'b0;
    thr_push_s = 1'b0;
    if (wr_evt_s) begin
      if (paddr_s == ADDR_LCR) begin
        lcr_wr_s = 1'b1;
      end else if (paddr_s == ADDR_THR) begin
        thr_push_s = ~dlab_r;
      end else begin
        lcr_wr_s   = 1'b0;
        thr_push_s = 1'b0;
      end
    end else begin
      lcr_wr_s   = 1'b0;
      thr_push_s = 1'b0;
    end
  end

  // Shadow of LCR[7].
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      dlab_r <= 1'b0;
    end else if (lcr_wr_s) begin
      dlab_r <= pwbyte_s[LCR_DLAB_BIT];
    end else begin
      dlab_r <= dlab_r;
    end
  end

  assign pop_s  = ~empty_s & char_ready;
  assign drop_s = thr_push_s & full_s & ~pop_s;

  // Saturating count of bytes lost to a full FIFO.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ovf_cnt_r <= 16'h0000;
    end else if (drop_s && (ovf_cnt_r != 16'hFFFF)) begin
      ovf_cnt_r <= ovf_cnt_r + 16'h0001;
    end else begin
      ovf_cnt_r <= ovf_cnt_r;
    end
  end

  uart_ctr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push      (thr_push_s),
    .push_data (pwbyte_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (fifo_level)
  );

  assign char_valid = ~empty_s;
  assign char_data  = head_s;
  assign char_eol   = ~empty_s & is_eol(head_s);
  assign dlab       = dlab_r;
  assign ovf_cnt    = ovf_cnt_r;

endmodule

// File: tb/tb_uart_ctr_sink.sv
// Directed bench for uart_ctr_sink: stimulus queues expected bytes, a
// monitor checks every byte handed over on the char_valid/char_ready stream.
module tb_uart_ctr_sink;

  logic         aclk;
  logic         aresetn;
  logic [127:0] uart_ctr_bus;
  logic         char_valid;
  logic         char_ready;
  logic [7:0]   char_data;
  logic         char_eol;
  logic [4:0]   fifo_level;
  logic         dlab;
  logic [15:0]  ovf_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  uart_ctr_sink #(.FIFO_DEPTH(16), .ADDR_THR(4'h0), .ADDR_LCR(4'h3)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .uart_ctr_bus (uart_ctr_bus),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .char_data    (char_data),
    .char_eol     (char_eol),
    .fifo_level   (fifo_level),
    .dlab         (dlab),
    .ovf_cnt      (ovf_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ignored bus bits are filled with noise so decoding must mask them.
  function automatic logic [127:0] mk_bus(input logic en, input logic wr,
                                          input logic [3:0] addr, input logic [7:0] data);
    logic [127:0] b;
    b = {128{1'b1}};
    b[127:96] = {24'hA5C3E1, data};
    b[67:64]  = addr;
    b[32]     = wr;
    b[0]      = en;
    return b;
  endfunction

  task automatic apb(input logic wr, input logic [3:0] addr, input logic [7:0] data,
                     input int waits, input logic rdy_on_evt);
    @(posedge aclk); #1;
    uart_ctr_bus = mk_bus(1'b0, wr, addr, data);
    @(posedge aclk); #1;
    uart_ctr_bus = mk_bus(1'b1, wr, addr, data);
    if (rdy_on_evt) char_ready = 1'b1;
    @(posedge aclk); #1;
    if (rdy_on_evt) char_ready = 1'b0;
    for (int i = 0; i < waits; i++) begin
      @(posedge aclk); #1;
    end
    uart_ctr_bus = 128'h0;
  endtask

  task automatic drain();
    char_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge aclk); #1;
      if (!char_valid) break;
    end
    char_ready = 1'b0;
    chk("drain_level", 32'(fifo_level), 32'd0);
  endtask

  // Scoreboard monitor: every accepted byte must match the queue head.
  always @(negedge aclk) begin
    if (aresetn && char_valid && char_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", 32'(char_data), 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("char_data", 32'(char_data), 32'(e));
        chk("char_eol", 32'(char_eol), 32'(e == 8'h0A));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    aresetn      = 1'b0;
    uart_ctr_bus = 128'h0;
    char_ready   = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_valid", 32'(char_valid), 32'd0);
    chk("rst_data",  32'(char_data),  32'd0);
    chk("rst_eol",   32'(char_eol),   32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_dlab",  32'(dlab),       32'd0);
    chk("rst_ovf",   32'(ovf_cnt),    32'd0);
    aresetn = 1'b1;

    // Single write, then one-cycle ready pulse.
    exp_q.push_back(8'h41);
    apb(1'b1, 4'h0, 8'h41, 0, 1'b0);
    chk("single_valid", 32'(char_valid), 32'd1);
    chk("single_data",  32'(char_data),  32'h41);
    chk("single_level", 32'(fifo_level), 32'd1);
    char_ready = 1'b1;
    @(posedge aclk); #1;
    char_ready = 1'b0;
    chk("single_pop_valid", 32'(char_valid), 32'd0);
    chk("single_pop_level", 32'(fifo_level), 32'd0);

    // Read access and unmapped address are ignored.
    apb(1'b0, 4'h0, 8'h55, 0, 1'b0);
    apb(1'b1, 4'h1, 8'h66, 0, 1'b0);
    chk("ignored_level", 32'(fifo_level), 32'd0);

    // Five-cycle wait-stated write gives one push.
    exp_q.push_back(8'h42);
    apb(1'b1, 4'h0, 8'h42, 4, 1'b0);
    repeat (2) @(posedge aclk);
    #1;
    chk("wait_level", 32'(fifo_level), 32'd1);
    drain();

    // DLAB gating.
    apb(1'b1, 4'h3, 8'h83, 0, 1'b0);
    chk("dlab_set", 32'(dlab), 32'd1);
    apb(1'b1, 4'h0, 8'h01, 0, 1'b0);
    chk("dll_level", 32'(fifo_level), 32'd0);
    apb(1'b1, 4'h3, 8'h03, 0, 1'b0);
    chk("dlab_clr", 32'(dlab), 32'd0);
    exp_q.push_back(8'h48);
    apb(1'b1, 4'h0, 8'h48, 0, 1'b0);
    chk("dlab_level", 32'(fifo_level), 32'd1);
    drain();

    // Overflow: 18 writes into a 16-deep FIFO.
    for (int i = 0; i < 18; i++) begin
      if (i < 16) exp_q.push_back(8'h50 + 8'(i));
      apb(1'b1, 4'h0, 8'h50 + 8'(i), 0, 1'b0);
    end
    chk("ovf_level", 32'(fifo_level), 32'd16);
    chk("ovf_cnt",   32'(ovf_cnt),    32'd2);

    // Full FIFO: push coincides with pop.
    exp_q.push_back(8'h70);
    apb(1'b1, 4'h0, 8'h70, 0, 1'b1);
    chk("full_pp_level", 32'(fifo_level), 32'd16);
    chk("full_pp_ovf",   32'(ovf_cnt),    32'd2);
    drain();

    // Reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      apb(1'b1, 4'h0, 8'h30 + 8'(i), 0, 1'b0);
    end
    apb(1'b1, 4'h3, 8'h80, 0, 1'b0);
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    chk("pre_rst_dlab",  32'(dlab),       32'd1);
    @(posedge aclk); #1;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    exp_q.delete();
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_valid", 32'(char_valid), 32'd0);
    chk("mid_rst_dlab",  32'(dlab),       32'd0);
    chk("mid_rst_ovf",   32'(ovf_cnt),    32'd0);

    exp_q.push_back(8'h0A);
    apb(1'b1, 4'h0, 8'h0A, 0, 1'b0);
    chk("eol_flag", 32'(char_eol),  32'd1);
    chk("eol_data", 32'(char_data), 32'h0A);
    drain();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
